// File: rtl/ecc_pkg.sv
// ---------------------------------------------------------------------------
// ecc_pkg
// Shared definitions for the GF(2^163) arithmetic blocks (multiplier, squarer,
// ladder datapath).
//   ECC_M        : field degree
//   ECC_POLY_LOW : f(x) with the x^163 term removed (x^7 + x^6 + x^3 + 1),
//                  XORed in whenever a shift carries out of bit 162
//   n_iter()     : number of digit iterations for a given digit width
//   mult_state_t : multiplier control states
// ---------------------------------------------------------------------------
package ecc_pkg;

    localparam int ECC_M = 163;

    localparam logic [ECC_M-1:0] ECC_POLY_LOW = 163'hC9;

    // ceil(ECC_M / digit)
    function automatic int n_iter(input int digit);
        return (ECC_M + digit - 1) / digit;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } mult_state_t;

endpackage

// File: rtl/gf2m_mulx.sv
// ---------------------------------------------------------------------------
// gf2m_mulx
// Combinational multiply-by-x in GF(2^163): o_v = i_v * x mod f(x).
// The bit shifted out of position 162 represents x^163, which is folded back
// as x^7 + x^6 + x^3 + 1.
//   i_v : 163-bit field element
//   o_v : 163-bit field element, i_v * x reduced
// ---------------------------------------------------------------------------
module gf2m_mulx
    import ecc_pkg::*;
(
    input  logic [ECC_M-1:0] i_v,
    output logic [ECC_M-1:0] o_v
);

    assign o_v = {i_v[ECC_M-2:0], 1'b0} ^ (i_v[ECC_M-1] ? ECC_POLY_LOW : '0);

endmodule

// File: rtl/gf2m_digit_mult.sv
// ---------------------------------------------------------------------------
// gf2m_digit_mult
// Digit-serial multiplier over GF(2^163), f(x) = x^163 + x^7 + x^6 + x^3 + 1.
// Operand b is consumed DIGIT bits per cycle, most significant digit first.
//
// Handshake: m_start is a level request. It is sampled only in IDLE; the
// accept edge captures a and b. m_done is a one-cycle pulse marking p valid.
// After completion the block waits in HOLD until m_start is seen low, so a
// request that stays high through the done cycle never starts a second
// multiply.
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   m_start : multiply request (level)
//   a, b    : 163-bit operands, sampled on the accept edge only
//   p       : product a*b mod f; held until the next accept
//   m_done  : completion pulse, one cycle
// ---------------------------------------------------------------------------
module gf2m_digit_mult
    import ecc_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m_start,
    input  logic [ECC_M-1:0] a,
    input  logic [ECC_M-1:0] b,
    output logic [ECC_M-1:0] p,
    output logic             m_done
);

    localparam int N  = n_iter(DIGIT);
    localparam int NW = N * DIGIT;                 // b zero-extended width
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    mult_state_t      r_state;
    logic [ECC_M-1:0] r_a;
    logic [NW-1:0]    r_b;
    logic [ECC_M-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_done;

    logic [DIGIT-1:0] w_digit;
    logic [NW-1:0]    w_b_shl;
    logic [ECC_M-1:0] w_next;

    assign w_digit = r_b[NW-1 -: DIGIT];

    // When a single digit covers the whole padded operand there is nothing
    // left to shift in.
    if (NW > DIGIT) begin : g_bshift
        assign w_b_shl = {r_b[NW-DIGIT-1:0], {DIGIT{1'b0}}};
    end else begin : g_bclr
        assign w_b_shl = '0;
    end

    // Two parallel Horner chains, DIGIT stages each:
    //   sh chain: acc * x^DIGIT mod f
    //   ad chain: a * digit mod f, digit bits applied MSB first
    // Both stay within 163 bits at every stage, so no wide product exists.
    for (genvar i = 0; i < DIGIT; i++) begin : g_step
        logic [ECC_M-1:0] w_sh_in;
        logic [ECC_M-1:0] w_sh_out;
        logic [ECC_M-1:0] w_ad_in;
        logic [ECC_M-1:0] w_ad_x;
        logic [ECC_M-1:0] w_ad_out;

        if (i == 0) begin : g_first
            assign w_sh_in = r_acc;
            assign w_ad_in = '0;
        end else begin : g_link
            assign w_sh_in = g_step[i-1].w_sh_out;
            assign w_ad_in = g_step[i-1].w_ad_out;
        end

        gf2m_mulx u_mulx_sh (
            .i_v (w_sh_in),
            .o_v (w_sh_out)
        );

        gf2m_mulx u_mulx_ad (
            .i_v (w_ad_in),
            .o_v (w_ad_x)
        );

        assign w_ad_out = w_ad_x ^ (r_a & {ECC_M{w_digit[DIGIT-1-i]}});
    end

    assign w_next = g_step[DIGIT-1].w_sh_out ^ g_step[DIGIT-1].w_ad_out;

    // Control and datapath registers. r_cnt holds the number of iterations
    // still to run after the current one, so cnt = 0 marks the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (m_start) begin
                        r_a     <= a;
                        r_b     <= NW'(b);
                        r_acc   <= '0;
                        r_cnt   <= CNT_LAST;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_next;
                    r_b   <= w_b_shl;
                    if (r_cnt == '0) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= HOLD;
                end
                HOLD: begin
                    r_done <= 1'b0;
                    if (!m_start) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign p      = r_acc;
    assign m_done = r_done;

endmodule

// File: tb/tb_gf2m_digit_mult.sv
// ---------------------------------------------------------------------------
// tb_gf2m_digit_mult
// Directed bench for gf2m_digit_mult. The main instance uses DIGIT=4; three
// more instances (DIGIT = 1, 8, 163) share the operand bus and have their own
// request line. Inputs are driven 1 time unit after a rising edge; outputs
// are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_gf2m_digit_mult;
  import ecc_pkg::*;

  localparam int W = ECC_M;

  logic         clk;
  logic         rst_n;
  logic         m_start;
  logic         m_start_x;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] p;
  logic         m_done;
  logic [W-1:0] p_x [3];
  logic         done_x [3];

  int checks;
  int failures;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  gf2m_digit_mult #(.DIGIT(4)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_start (m_start),
    .a       (a),
    .b       (b),
    .p       (p),
    .m_done  (m_done)
  );

  gf2m_digit_mult #(.DIGIT(1)) u_d1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_start (m_start_x),
    .a       (a),
    .b       (b),
    .p       (p_x[0]),
    .m_done  (done_x[0])
  );

  gf2m_digit_mult #(.DIGIT(8)) u_d8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_start (m_start_x),
    .a       (a),
    .b       (b),
    .p       (p_x[1]),
    .m_done  (done_x[1])
  );

  gf2m_digit_mult #(.DIGIT(163)) u_d163 (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_start (m_start_x),
    .a       (a),
    .b       (b),
    .p       (p_x[2]),
    .m_done  (done_x[2])
  );

  // ---------------- golden model ----------------
  // Full carry-less product, then reduction from the top bit down.
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-2:0] c;
    logic [2*W-2:0] f;
    c = '0;
    f = '0;
    f[W] = 1'b1;
    f[7] = 1'b1;
    f[6] = 1'b1;
    f[3] = 1'b1;
    f[0] = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (y[i]) c = c ^ ((2*W-1)'(x) << i);
    end
    for (int i = 2*W-2; i >= W; i--) begin
      if (c[i]) c = c ^ (f << (i - W));
    end
    return c[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_fe();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present operands and raise the request; the next edge is the accept edge.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb);
    a       = ta;
    b       = tb;
    m_start = 1'b1;
    @(posedge clk); #1;
  endtask

  // Count edges after the accept edge until m_done is seen (bounded).
  task automatic wait_done(output int cyc, input bit scramble);
    bit got;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 300) begin
      if (scramble) begin
        a       = rand_fe();
        b       = rand_fe();
        m_start = ~m_start;
      end
      @(posedge clk); #1;
      cyc++;
      got = m_done;
    end
    m_start = 1'b1;
  endtask

  // Cycle after m_done: pulse gone, product held; then drop the request
  // and let HOLD return to IDLE.
  task automatic finish_mul(input string tag, input logic [W-1:0] exp);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, W'(m_done), '0);
    check({tag, "_p_held"}, p, exp);
    m_start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_mul(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [W-1:0] exp, input bit scramble);
    int cyc;
    launch(ta, tb);
    wait_done(cyc, scramble);
    check({tag, "_lat"}, W'(cyc), W'(41));
    check({tag, "_p"}, p, exp);
    finish_mul(tag, exp);
  endtask

  // All three extra instances at once; the request stays high long after
  // the slowest one finishes, so each must pulse exactly once.
  task automatic do_multi(input int v, input logic [W-1:0] ta, input logic [W-1:0] tb);
    int lat [3];
    int nd [3];
    int exp_lat [3];
    int dig [3];
    logic [W-1:0] e;
    exp_lat = '{163, 21, 1};
    dig     = '{1, 8, 163};
    e = ref_mul(ta, tb);
    for (int k = 0; k < 3; k++) begin
      lat[k] = 0;
      nd[k]  = 0;
    end
    a         = ta;
    b         = tb;
    m_start_x = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 180; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        if (done_x[k]) begin
          nd[k]++;
          lat[k] = c;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("multi%0d_d%0d_ndone", v, dig[k]), W'(nd[k]), W'(1));
      check($sformatf("multi%0d_d%0d_lat", v, dig[k]), W'(lat[k]), W'(exp_lat[k]));
      check($sformatf("multi%0d_d%0d_p", v, dig[k]), p_x[k], e);
    end
    m_start_x = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [167:0] pat;
    logic [W-1:0] vb;
    logic [W-1:0] x162;
    logic [W-1:0] e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           cyc;
    int           ndone;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    m_start   = 1'b0;
    m_start_x = 1'b0;
    a         = '0;
    b         = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_p", p, '0);
    check("rst_done", W'(m_done), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_done", W'(m_done), '0);

    // directed products
    pat  = {21{8'h5A}};
    vb   = pat[W-1:0];
    x162 = '0;
    x162[162] = 1'b1;
    do_mul("one_times_pat", W'(1), vb, vb, 1'b0);
    do_mul("x162_times_x", x162, W'(2), W'(8'hC9), 1'b0);
    do_mul("a_zero", '0, vb, '0, 1'b0);
    do_mul("b_zero", vb, '0, '0, 1'b0);
    do_mul("xp1_sq", W'(3), W'(3), W'(5), 1'b0);
    // x^170 = x^14 + x^13 + x^10 + x^7
    do_mul("x100_x70", W'(1) << 100, W'(1) << 70, W'(16'h6480), 1'b0);
    // x^324 = x^161 + x^12 + x^10 + x^5 + x
    e = W'(16'h1422);
    e[161] = 1'b1;
    do_mul("x162_sq", x162, x162, e, 1'b0);

    // model-backed vectors
    for (int v = 0; v < 3; v++) begin
      ra = rand_fe();
      rb = rand_fe();
      do_mul($sformatf("rand%0d", v), ra, rb, ref_mul(ra, rb), 1'b0);
    end

    // operands and request disturbed during RUN
    ra = rand_fe();
    rb = rand_fe();
    do_mul("scramble", ra, rb, ref_mul(ra, rb), 1'b1);

    // FSM-style handshake: request held through DONE and into HOLD
    ra = rand_fe();
    rb = rand_fe();
    e  = ref_mul(ra, rb);
    launch(ra, rb);
    wait_done(cyc, 1'b0);
    check("hs1_lat", W'(cyc), W'(41));
    check("hs1_p", p, e);
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (m_done) ndone++;
    end
    check("hs_no_restart_done", W'(ndone), '0);
    check("hs_no_restart_p", p, e);
    m_start = 1'b0;
    @(posedge clk); #1;
    ra = rand_fe();
    rb = rand_fe();
    e  = ref_mul(ra, rb);
    launch(ra, rb);
    wait_done(cyc, 1'b0);
    check("hs2_lat", W'(cyc), W'(41));
    check("hs2_p", p, e);
    finish_mul("hs2", e);

    // reset in the middle of RUN, released with the request already high
    launch(rand_fe(), rand_fe());
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_done", W'(m_done), '0);
    check("midrst_p", p, '0);
    ra = rand_fe();
    rb = rand_fe();
    e  = ref_mul(ra, rb);
    a  = ra;
    b  = rb;
    m_start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_p", p, '0);
    check("postrst_done", W'(m_done), '0);
    @(posedge clk); #1;
    wait_done(cyc, 1'b0);
    check("postrst_lat", W'(cyc), W'(41));
    check("postrst_p_final", p, e);
    finish_mul("postrst", e);

    // other digit widths
    do_multi(0, rand_fe(), rand_fe());
    do_multi(1, W'(1), vb);
    do_multi(2, x162, x162);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
